// File: rtl/uart_pkg.sv
`default_nettype none
//==== uart_pkg : oversample constants, TX/RX state types, parity helper ====
//==== Rev 1.0 ===============================================================
package uart_pkg;

  localparam int OVERSAMPLE = 16;
  localparam int TICK_W     = $clog2(OVERSAMPLE);

  typedef enum logic [2:0] {
    TX_IDLE   = 3'd0,
    TX_START  = 3'd1,
    TX_DATA   = 3'd2,
    TX_PARITY = 3'd3,
    TX_STOP   = 3'd4
  } tx_state_t;

  typedef enum logic [2:0] {
    RX_IDLE      = 3'd0,
    RX_START     = 3'd1,
    RX_DATA      = 3'd2,
    RX_PARITY    = 3'd3,
    RX_STOP      = 3'd4,
    RX_WAIT_HIGH = 3'd5
  } rx_state_t;

  // Callers zero-extend narrower words; the extra zero bits do not change the XOR.
  function automatic logic calc_parity(input logic [8:0] data, input logic odd);
    return (^data) ^ odd;
  endfunction

endpackage
`default_nettype wire

// File: rtl/uart_baud_gen.sv
`default_nettype none
//==== uart_baud_gen : clk divider producing oversample ticks and tick index ====
//==== Rev 1.0 ==================================================================
module uart_baud_gen
  import uart_pkg::*;
#(
  parameter int BAUD_DIV = 27
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_restart,
  output logic              o_tick,
  output logic [TICK_W-1:0] o_tick_idx
);

  localparam int DIV_W = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;
  localparam logic [DIV_W-1:0] c_div_last = DIV_W'(BAUD_DIV - 1);

  logic [DIV_W-1:0]  r_div;
  logic [TICK_W-1:0] r_idx;
  logic              w_tick;

  // o_tick marks the last clk of each oversample tick; o_tick_idx is the tick in progress.
  assign w_tick     = (r_div == c_div_last);
  assign o_tick     = w_tick;
  assign o_tick_idx = r_idx;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_div <= '0;
      r_idx <= '0;
    end else if (i_restart) begin
      r_div <= '0;
      r_idx <= '0;
    end else if (w_tick) begin
      r_div <= '0;
      r_idx <= r_idx + 1'b1;
    end else begin
      r_div <= r_div + 1'b1;
    end
  end

endmodule
`default_nettype wire

// File: rtl/uart_param.sv
`default_nettype none
//==== uart_param : parameterised full-duplex UART, 16x oversampled receiver ====
//==== Rev 1.0 ==================================================================
module uart_param
  import uart_pkg::*;
#(
  parameter int DATA_W     = 8,
  parameter int BAUD_DIV   = 27,
  parameter int PARITY_EN  = 1,
  parameter int PARITY_ODD = 0,
  parameter int STOP_BITS  = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] tx_data,
  input  logic              tx_valid,
  output logic              tx_ready,
  output logic              tx_out,
  input  logic              rx_in,
  output logic [DATA_W-1:0] rx_data,
  output logic              rx_valid,
  output logic              parity_error,
  output logic              stop_error
);

  localparam logic [3:0]        c_last_data = 4'(DATA_W - 1);
  localparam logic [3:0]        c_last_stop = 4'(STOP_BITS - 1);
  localparam logic              c_odd       = (PARITY_ODD != 0);
  localparam logic [TICK_W-1:0] c_idx_last  = TICK_W'(OVERSAMPLE - 1);
  localparam logic [TICK_W-1:0] c_idx_mid   = TICK_W'(OVERSAMPLE / 2 - 1);

  tx_state_t         r_tx_state, w_tx_state_nxt;
  logic [DATA_W-1:0] r_tx_shift, w_tx_shift_nxt;
  logic [3:0]        r_tx_cnt, w_tx_cnt_nxt;
  logic              r_tx_par, w_tx_par_nxt;
  logic              r_tx_out, w_tx_out_nxt;
  logic              w_tx_accept, w_tx_tick, w_tx_bit_end;
  logic [TICK_W-1:0] w_tx_idx;

  assign tx_ready     = (r_tx_state == TX_IDLE);
  assign tx_out       = r_tx_out;
  assign w_tx_accept  = tx_valid && tx_ready;
  assign w_tx_bit_end = w_tx_tick && (w_tx_idx == c_idx_last);

  uart_baud_gen #(.BAUD_DIV(BAUD_DIV)) u_tx_baud (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_restart (w_tx_accept),
    .o_tick    (w_tx_tick),
    .o_tick_idx(w_tx_idx)
  );

  // tx_out is registered: each transition computes the level of the bit that starts next.
  always_comb begin
    w_tx_state_nxt = r_tx_state;
    w_tx_shift_nxt = r_tx_shift;
    w_tx_cnt_nxt   = r_tx_cnt;
    w_tx_par_nxt   = r_tx_par;
    w_tx_out_nxt   = r_tx_out;
    case (r_tx_state)
      TX_IDLE: begin
        w_tx_out_nxt = 1'b1;
        if (w_tx_accept) begin
          w_tx_state_nxt = TX_START;
          w_tx_out_nxt   = 1'b0;
          w_tx_shift_nxt = tx_data;
          w_tx_par_nxt   = calc_parity(9'(tx_data), c_odd);
        end
      end
      TX_START: if (w_tx_bit_end) begin
        w_tx_state_nxt = TX_DATA;
        w_tx_out_nxt   = r_tx_shift[0];
        w_tx_cnt_nxt   = '0;
      end
      TX_DATA: if (w_tx_bit_end) begin
        if (r_tx_cnt == c_last_data) begin
          w_tx_cnt_nxt = '0;
          if (PARITY_EN != 0) begin
            w_tx_state_nxt = TX_PARITY;
            w_tx_out_nxt   = r_tx_par;
          end else begin
            w_tx_state_nxt = TX_STOP;
            w_tx_out_nxt   = 1'b1;
          end
        end else begin
          w_tx_shift_nxt = r_tx_shift >> 1;
          w_tx_out_nxt   = r_tx_shift[1];
          w_tx_cnt_nxt   = r_tx_cnt + 1'b1;
        end
      end
      TX_PARITY: if (w_tx_bit_end) begin
        w_tx_state_nxt = TX_STOP;
        w_tx_out_nxt   = 1'b1;
        w_tx_cnt_nxt   = '0;
      end
      TX_STOP: if (w_tx_bit_end) begin
        if (r_tx_cnt == c_last_stop) w_tx_state_nxt = TX_IDLE;
        else                         w_tx_cnt_nxt   = r_tx_cnt + 1'b1;
      end
      default: w_tx_state_nxt = TX_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_tx_state <= TX_IDLE;
      r_tx_shift <= '0;
      r_tx_cnt   <= '0;
      r_tx_par   <= 1'b0;
      r_tx_out   <= 1'b1;
    end else begin
      r_tx_state <= w_tx_state_nxt;
      r_tx_shift <= w_tx_shift_nxt;
      r_tx_cnt   <= w_tx_cnt_nxt;
      r_tx_par   <= w_tx_par_nxt;
      r_tx_out   <= w_tx_out_nxt;
    end
  end

  logic              r_sync1, r_sync2;
  rx_state_t         r_rx_state, w_rx_state_nxt;
  logic [DATA_W-1:0] r_rx_shift, w_rx_shift_nxt;
  logic [3:0]        r_rx_cnt, w_rx_cnt_nxt;
  logic              r_rx_par, w_rx_par_nxt;
  logic              w_rx_start, w_rx_done, w_rx_tick, w_rx_mid;
  logic [TICK_W-1:0] w_rx_idx;
  logic              r_rx_valid, r_par_err, r_stop_err;
  logic [DATA_W-1:0] r_rx_data;

  assign w_rx_start   = (r_rx_state == RX_IDLE) && !r_sync2;
  assign w_rx_mid     = w_rx_tick && (w_rx_idx == c_idx_mid);
  assign rx_valid     = r_rx_valid;
  assign rx_data      = r_rx_data;
  assign parity_error = r_par_err;
  assign stop_error   = r_stop_err;

  uart_baud_gen #(.BAUD_DIV(BAUD_DIV)) u_rx_baud (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_restart (w_rx_start),
    .o_tick    (w_rx_tick),
    .o_tick_idx(w_rx_idx)
  );

  always_comb begin
    w_rx_state_nxt = r_rx_state;
    w_rx_shift_nxt = r_rx_shift;
    w_rx_cnt_nxt   = r_rx_cnt;
    w_rx_par_nxt   = r_rx_par;
    w_rx_done      = 1'b0;
    case (r_rx_state)
      RX_IDLE: if (!r_sync2) w_rx_state_nxt = RX_START;
      RX_START: if (w_rx_mid) begin
        w_rx_state_nxt = r_sync2 ? RX_IDLE : RX_DATA;
        w_rx_cnt_nxt   = '0;
      end
      RX_DATA: if (w_rx_mid) begin
        w_rx_shift_nxt = {r_sync2, r_rx_shift[DATA_W-1:1]};
        if (r_rx_cnt == c_last_data) begin
          w_rx_state_nxt = (PARITY_EN != 0) ? RX_PARITY : RX_STOP;
          w_rx_cnt_nxt   = '0;
        end else begin
          w_rx_cnt_nxt = r_rx_cnt + 1'b1;
        end
      end
      RX_PARITY: if (w_rx_mid) begin
        w_rx_par_nxt   = r_sync2;
        w_rx_state_nxt = RX_STOP;
      end
      // Only the first stop bit is checked; a low one is a framing error or break.
      RX_STOP: if (w_rx_mid) begin
        w_rx_done      = 1'b1;
        w_rx_state_nxt = r_sync2 ? RX_IDLE : RX_WAIT_HIGH;
      end
      RX_WAIT_HIGH: if (r_sync2) w_rx_state_nxt = RX_IDLE;
      default: w_rx_state_nxt = RX_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync1    <= 1'b1;
      r_sync2    <= 1'b1;
      r_rx_state <= RX_IDLE;
      r_rx_shift <= '0;
      r_rx_cnt   <= '0;
      r_rx_par   <= 1'b0;
      r_rx_valid <= 1'b0;
      r_rx_data  <= '0;
      r_par_err  <= 1'b0;
      r_stop_err <= 1'b0;
    end else begin
      r_sync1    <= rx_in;
      r_sync2    <= r_sync1;
      r_rx_state <= w_rx_state_nxt;
      r_rx_shift <= w_rx_shift_nxt;
      r_rx_cnt   <= w_rx_cnt_nxt;
      r_rx_par   <= w_rx_par_nxt;
      r_rx_valid <= w_rx_done;
      if (w_rx_done) begin
        r_rx_data  <= r_rx_shift;
        r_par_err  <= (PARITY_EN != 0) && (calc_parity(9'(r_rx_shift), c_odd) != r_rx_par);
        r_stop_err <= !r_sync2;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_uart_param.sv
`default_nettype none
//==== tb_uart_param : self-checking bench, 8E1 (dut_a) and 8O2 (dut_b), BAUD_DIV=2 ====
//==== Rev 1.0 ========================================================================
module tb_uart_param;

  localparam int BIT = 32;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n;
  logic [1:0] tx_valid;
  logic [1:0] loop;
  logic [1:0] rx_drv;
  logic [7:0] tx_data [2];
  wire  [1:0] tx_ready, tx_out, rx_valid, perr, serr, rx_line;
  wire  [7:0] rxd_a, rxd_b;

  assign rx_line = (loop & tx_out) | (~loop & rx_drv);

  uart_param #(.DATA_W(8), .BAUD_DIV(2), .PARITY_EN(1), .PARITY_ODD(0), .STOP_BITS(1)) dut_a (
    .clk(clk), .rst_n(rst_n), .tx_data(tx_data[0]), .tx_valid(tx_valid[0]),
    .tx_ready(tx_ready[0]), .tx_out(tx_out[0]), .rx_in(rx_line[0]), .rx_data(rxd_a),
    .rx_valid(rx_valid[0]), .parity_error(perr[0]), .stop_error(serr[0]));

  uart_param #(.DATA_W(8), .BAUD_DIV(2), .PARITY_EN(1), .PARITY_ODD(1), .STOP_BITS(2)) dut_b (
    .clk(clk), .rst_n(rst_n), .tx_data(tx_data[1]), .tx_valid(tx_valid[1]),
    .tx_ready(tx_ready[1]), .tx_out(tx_out[1]), .rx_in(rx_line[1]), .rx_data(rxd_b),
    .rx_valid(rx_valid[1]), .parity_error(perr[1]), .stop_error(serr[1]));

  int nvec = 0;
  int nerr = 0;

  typedef struct packed {
    logic [7:0] d;
    logic       pe;
    logic       se;
  } rxrec_t;

  rxrec_t q_a[$];
  rxrec_t q_b[$];

  always @(negedge clk) begin
    if (rx_valid[0] === 1'b1) q_a.push_back({rxd_a, perr[0], serr[0]});
    if (rx_valid[1] === 1'b1) q_b.push_back({rxd_b, perr[1], serr[1]});
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic chk_qsize(input int d, input int exp);
    chk($sformatf("rx_count_dut%0d", d), (d == 0) ? q_a.size() : q_b.size(), exp);
  endtask

  task automatic chk_rx(input int d, input logic [7:0] ed, input logic epe, input logic ese);
    rxrec_t r;
    int     n;
    n = (d == 0) ? q_a.size() : q_b.size();
    chk($sformatf("rx_present_dut%0d", d), (n > 0), 1);
    if (n > 0) begin
      if (d == 0) r = q_a.pop_front();
      else        r = q_b.pop_front();
      chk("rx_data", r.d, ed);
      chk("rx_parity_error", r.pe, epe);
      chk("rx_stop_error", r.se, ese);
    end
  endtask

  task automatic wait_ready(input int d);
    int t = 0;
    while (tx_ready[d] !== 1'b1 && t < 2000) begin
      @(negedge clk);
      t++;
    end
    if (t >= 2000) begin
      nvec++;
      nerr++;
      $display("FAIL tx_ready_timeout dut%0d: got %b expected 1 within 2000 clk", d, tx_ready[d]);
    end
  endtask

  task automatic send(input int d, input logic [7:0] data);
    @(negedge clk);
    wait_ready(d);
    tx_data[d]  = data;
    tx_valid[d] = 1'b1;
    @(posedge clk);
    #1;
    tx_valid[d] = 1'b0;
  endtask

  // Called at #1 after the accept edge: checks every bit at mid-period and the busy span.
  task automatic check_frame(input int d, input logic [11:0] frame, input int len);
    int low = 0;
    for (int n = 0; n <= BIT * len + 1; n++) begin
      if (n % BIT == BIT / 2) chk($sformatf("tx_bit%0d_dut%0d", n / BIT, d), tx_out[d], frame[n / BIT]);
      if (tx_ready[d] === 1'b0 && low == n) low++;
      @(posedge clk);
      #1;
    end
    chk("tx_ready_low_cycles", low, BIT * len);
    chk("tx_idle_high", tx_out[d], 1);
  endtask

  task automatic drive_frame(input int d, input logic [11:0] frame, input int len);
    for (int k = 0; k < len; k++) begin
      rx_drv[d] = frame[k];
      repeat (BIT) @(posedge clk);
    end
    rx_drv[d] = 1'b1;
  endtask

  // Reference frame built from the line protocol: start, data LSB first, parity, stop bits.
  function automatic logic [11:0] model_frame(input logic [7:0] data, input bit odd,
                                              input int stops, output int len);
    int          ones = 0;
    logic [11:0] f    = '1;
    f[0] = 1'b0;
    for (int i = 0; i < 8; i++) begin
      f[1 + i] = data[i];
      ones += int'(data[i]);
    end
    f[9] = ((ones % 2) == 1) ^ odd;
    len  = 10 + stops;
    return f;
  endfunction

  typedef struct {
    int          dut;
    logic [7:0]  data;
    int          len;
    logic [11:0] frame;
  } txvec_t;

  txvec_t tv [8];

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [11:0] f;
    logic [7:0]  v;
    int          len;
    int          d;
    logic        pflip;
    logic        sflip;

    tv[0] = '{0, 8'hA5, 11, {2'b11, 1'b0, 8'hA5, 1'b0}};
    tv[1] = '{0, 8'h00, 11, {2'b11, 1'b0, 8'h00, 1'b0}};
    tv[2] = '{0, 8'hFF, 11, {2'b11, 1'b0, 8'hFF, 1'b0}};
    tv[3] = '{0, 8'h01, 11, {2'b11, 1'b1, 8'h01, 1'b0}};
    tv[4] = '{1, 8'h55, 12, {2'b11, 1'b1, 8'h55, 1'b0}};
    tv[5] = '{1, 8'h80, 12, {2'b11, 1'b0, 8'h80, 1'b0}};
    tv[6] = '{1, 8'hFF, 12, {2'b11, 1'b1, 8'hFF, 1'b0}};
    tv[7] = '{1, 8'h3C, 12, {2'b11, 1'b1, 8'h3C, 1'b0}};

    rst_n      = 1'b0;
    tx_valid   = 2'b00;
    tx_data[0] = 8'h00;
    tx_data[1] = 8'h00;
    loop       = 2'b11;
    rx_drv     = 2'b11;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_tx_out", tx_out, 2'b11);
    chk("reset_tx_ready", tx_ready, 2'b11);
    chk("reset_rx_valid", rx_valid, 2'b00);
    chk("reset_rx_data_a", rxd_a, 8'h00);
    chk("reset_rx_data_b", rxd_b, 8'h00);
    chk("reset_parity_error", perr, 2'b00);
    chk("reset_stop_error", serr, 2'b00);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 8; i++) begin
      send(tv[i].dut, tv[i].data);
      check_frame(tv[i].dut, tv[i].frame, tv[i].len);
      chk_rx(tv[i].dut, tv[i].data, 1'b0, 1'b0);
      chk_qsize(tv[i].dut, 0);
    end

    // Back-to-back loopback: valid held high, second word accepted on first ready cycle.
    @(negedge clk);
    tx_data[0]  = 8'h3C;
    tx_valid[0] = 1'b1;
    @(posedge clk);
    #1;
    chk("b2b_first_accept", tx_ready[0], 0);
    @(negedge clk);
    tx_data[0] = 8'hFF;
    wait_ready(0);
    @(posedge clk);
    #1;
    chk("b2b_second_accept", tx_ready[0], 0);
    tx_valid[0] = 1'b0;
    repeat (12 * BIT) @(posedge clk);
    chk_qsize(0, 2);
    chk_rx(0, 8'h3C, 1'b0, 1'b0);
    chk_rx(0, 8'hFF, 1'b0, 1'b0);

    // Odd-parity receiver fed 0x55 with the parity bit inverted.
    loop[1] = 1'b0;
    repeat (BIT) @(posedge clk);
    drive_frame(1, {2'b11, 1'b0, 8'h55, 1'b0}, 12);
    repeat (BIT) @(posedge clk);
    #1;
    chk("parity_error_held", perr[1], 1);
    chk_rx(1, 8'h55, 1'b1, 1'b0);
    chk_qsize(1, 0);

    // Break: line low for 20 bit periods.
    loop[0]   = 1'b0;
    rx_drv[0] = 1'b0;
    repeat (20 * BIT) @(posedge clk);
    #1;
    chk("break_stop_error_held", serr[0], 1);
    chk_qsize(0, 1);
    chk_rx(0, 8'h00, 1'b0, 1'b1);
    rx_drv[0] = 1'b1;
    repeat (4 * BIT) @(posedge clk);
    chk_qsize(0, 0);

    // False start: 10 clk low glitch.
    rx_drv[0] = 1'b0;
    repeat (10) @(posedge clk);
    rx_drv[0] = 1'b1;
    repeat (12 * BIT) @(posedge clk);
    chk_qsize(0, 0);

    // Injected frames with random parity/stop corruption.
    for (int i = 0; i < 6; i++) begin
      v     = 8'($urandom_range(0, 255));
      pflip = 1'($urandom_range(0, 1));
      sflip = 1'($urandom_range(0, 1));
      f     = model_frame(v, 1'b0, 1, len);
      f[9]  = f[9] ^ pflip;
      f[10] = ~sflip;
      drive_frame(0, f, len);
      repeat (BIT) @(posedge clk);
      chk_rx(0, v, pflip, sflip);
      chk_qsize(0, 0);
    end

    // Random loopback traffic on both configurations.
    loop = 2'b11;
    repeat (2 * BIT) @(posedge clk);
    for (int i = 0; i < 12; i++) begin
      d = i % 2;
      v = 8'($urandom_range(0, 255));
      f = model_frame(v, (d == 1), (d == 0) ? 1 : 2, len);
      repeat ($urandom_range(0, 5)) @(posedge clk);
      send(d, v);
      check_frame(d, f, len);
      chk_rx(d, v, 1'b0, 1'b0);
      chk_qsize(d, 0);
    end

    // Reset in the middle of the data bits on both paths.
    send(0, 8'h5A);
    send(1, 8'hC3);
    repeat (100) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("midreset_tx_out", tx_out, 2'b11);
    chk("midreset_tx_ready", tx_ready, 2'b11);
    chk("midreset_rx_valid", rx_valid, 2'b00);
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (14 * BIT) @(posedge clk);
    chk_qsize(0, 0);
    chk_qsize(1, 0);
    send(0, 8'h81);
    check_frame(0, {2'b11, 1'b0, 8'h81, 1'b0}, 11);
    chk_rx(0, 8'h81, 1'b0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
`default_nettype wire
